// File: rtl/hydra_pkg.sv
// -----------------------------------------------------------------------------
// hydra_pkg
// Shared definitions for the hydra ingress framer:
//   - header field widths (LEN_W, PRIO_W, DEST_W) and derived widths
//   - hdr_t  : packed 16-bit hydra packet header {rsvd, len, prio, dest}
//   - desc_t : packed 12-bit packet descriptor   {len, prio, dest}
//   - framer_state_e : output framing FSM states
//   - make_header() : builds the header word from a descriptor
// -----------------------------------------------------------------------------
package hydra_pkg;

  localparam int LEN_W  = 8;
  localparam int PRIO_W = 2;
  localparam int DEST_W = 2;
  localparam int HDR_W  = 16;
  localparam int DESC_W = LEN_W + PRIO_W + DEST_W;
  localparam int RSVD_W = HDR_W - DESC_W;

  typedef struct packed {
    logic [RSVD_W-1:0] rsvd;
    logic [LEN_W-1:0]  len;
    logic [PRIO_W-1:0] prio;
    logic [DEST_W-1:0] dest;
  } hdr_t;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [PRIO_W-1:0] prio;
    logic [DEST_W-1:0] dest;
  } desc_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOP  = 3'd1,
    ST_HDR  = 3'd2,
    ST_DATA = 3'd3,
    ST_EOP  = 3'd4
  } framer_state_e;

  function automatic hdr_t make_header(input desc_t d);
    hdr_t h;
    h.rsvd = {RSVD_W{1'b0}};
    h.len  = d.len;
    h.prio = d.prio;
    h.dest = d.dest;
    return h;
  endfunction

endpackage

// File: rtl/hydra_sync_fifo.sv
// -----------------------------------------------------------------------------
// hydra_sync_fifo
// Single-clock show-ahead FIFO: o_rdata always presents the oldest entry, a pop
// consumes it. A push and a pop in the same cycle leave the occupancy unchanged,
// and a push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle. Pointers wrap modulo DEPTH (DEPTH need not be a power of two).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_push, i_wdata : write strobe and data
//   i_pop           : consume the head entry (ignored when empty)
//   o_rdata         : head entry
//   o_full, o_empty : occupancy == DEPTH / occupancy == 0
//   o_count         : current occupancy
// -----------------------------------------------------------------------------
module hydra_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_C);
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO can still take a word if the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array write; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_C) ? {PW{1'b0}} : r_wr_ptr + PW'(1'b1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_C) ? {PW{1'b0}} : r_rd_ptr + PW'(1'b1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hydra_ingress_framer.sv
// -----------------------------------------------------------------------------
// hydra_ingress_framer
// Store-and-forward source stage in front of a hydra switch write port. Payload
// words are buffered in a payload FIFO; when the last beat of a packet arrives a
// descriptor {len, prio, dest} is queued. The output FSM then emits
// wr_sop, the header word, len payload words (gap-free) and wr_eop, starting a
// packet only while pause is low. Words past MAX_LEN are accepted but dropped
// and the packet is marked truncated.
//
// Optional build macro: HYDRA_FRAMER_STATS_EN
//   defined   -> pkt_cnt counts wr_eop strobes, trunc_cnt counts truncated
//                packets (both wrap at 2^16)
//   undefined -> pkt_cnt / trunc_cnt are constant 0
//
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last  : input word stream
//   s_dest, s_prio                 : sampled on the first beat of a packet
//   pause                          : hydra back-pressure, checked only between packets
//   wr_sop/wr_vld/wr_data/wr_eop   : hydra write framing (all registered)
//   pkt_cnt, trunc_cnt             : optional statistics
// -----------------------------------------------------------------------------
module hydra_ingress_framer
  import hydra_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int DESC_DEPTH = 4,
  parameter int MAX_LEN    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  input  logic [1:0]  s_dest,
  input  logic [1:0]  s_prio,
  input  logic        pause,
  output logic        wr_sop,
  output logic        wr_vld,
  output logic [15:0] wr_data,
  output logic        wr_eop,
  output logic [15:0] pkt_cnt,
  output logic [15:0] trunc_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam int PCW = $clog2(DEPTH + 1);
  localparam int DCW = $clog2(DESC_DEPTH + 1);

  // ---------------- input side ----------------
  logic              w_accept;
  logic              w_store;
  logic              w_first;
  logic              w_trunc;
  logic              w_desc_push;
  logic [LEN_W-1:0]  w_len;
  desc_t             w_desc_in;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_trunc;
  logic [DEST_W-1:0] r_dest;
  logic [PRIO_W-1:0] r_prio;

  // ---------------- FIFO status ----------------
  logic [15:0]       w_pay_rdata;
  logic              w_pay_full;
  logic              w_pay_empty;
  logic [PCW-1:0]    w_pay_count;
  desc_t             w_desc_out;
  logic              w_desc_full;
  logic              w_desc_empty;
  logic [DCW-1:0]    w_desc_count;
  logic              w_unused;

  // ---------------- output side ----------------
  framer_state_e     r_state;
  framer_state_e     w_state_nxt;
  logic [LEN_W-1:0]  r_left;
  logic [LEN_W-1:0]  w_left_nxt;
  logic              r_wr_sop;
  logic              r_wr_vld;
  logic [15:0]       r_wr_data;
  logic              r_wr_eop;
  logic              w_sop_nxt;
  logic              w_vld_nxt;
  logic [15:0]       w_data_nxt;
  logic              w_eop_nxt;
  logic              w_desc_pop;
  logic              w_pay_pop;

  assign s_ready  = !w_pay_full && !w_desc_full;
  assign w_accept = s_valid && s_ready;

  // Occupancy detail beyond full/empty is not needed here.
  assign w_unused = ^{w_pay_empty, w_pay_count, w_desc_count};

  // Per-beat decode: first-beat detection, store/drop decision, running length.
  always_comb begin
    w_first        = (r_cnt == {LEN_W{1'b0}});
    w_store        = w_accept && (r_cnt < MAX_LEN_C);
    w_trunc        = r_trunc || (w_accept && !w_store);
    // Once truncation starts r_cnt sits at MAX_LEN, so this saturates naturally.
    w_len          = w_store ? (r_cnt + 8'd1) : r_cnt;
    w_desc_push    = w_accept && s_last;
    w_desc_in.len  = w_len;
    w_desc_in.prio = w_first ? s_prio : r_prio;
    w_desc_in.dest = w_first ? s_dest : r_dest;
  end

  // Input packet tracking: stored-word count, truncation flag, first-beat fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= {LEN_W{1'b0}};
      r_trunc <= 1'b0;
      r_dest  <= {DEST_W{1'b0}};
      r_prio  <= {PRIO_W{1'b0}};
    end else if (w_accept) begin
      if (s_last) begin
        r_cnt   <= {LEN_W{1'b0}};
        r_trunc <= 1'b0;
      end else begin
        r_cnt   <= w_len;
        r_trunc <= w_trunc;
      end
      if (w_first) begin
        r_dest <= s_dest;
        r_prio <= s_prio;
      end
    end
  end

  hydra_sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_pay_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_store),
    .i_wdata (s_data),
    .i_pop   (w_pay_pop),
    .o_rdata (w_pay_rdata),
    .o_full  (w_pay_full),
    .o_empty (w_pay_empty),
    .o_count (w_pay_count)
  );

  hydra_sync_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_desc_push),
    .i_wdata (w_desc_in),
    .i_pop   (w_desc_pop),
    .o_rdata (w_desc_out),
    .o_full  (w_desc_full),
    .o_empty (w_desc_empty),
    .o_count (w_desc_count)
  );

  // Output FSM: next state plus the values the output registers take next cycle.
  // Outputs are computed for the state being entered, so each strobe appears
  // in the same cycle as its state.
  always_comb begin
    w_state_nxt = r_state;
    w_left_nxt  = r_left;
    w_sop_nxt   = 1'b0;
    w_vld_nxt   = 1'b0;
    w_data_nxt  = 16'h0000;
    w_eop_nxt   = 1'b0;
    w_desc_pop  = 1'b0;
    w_pay_pop   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_desc_empty && !pause) begin
          w_state_nxt = ST_SOP;
          w_sop_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SOP: begin
        w_state_nxt = ST_HDR;
        w_vld_nxt   = 1'b1;
        w_data_nxt  = make_header(w_desc_out);
        w_desc_pop  = 1'b1;
        w_left_nxt  = w_desc_out.len;
      end
      ST_HDR: begin
        // len >= 1, so the first payload word always follows the header.
        w_state_nxt = ST_DATA;
        w_vld_nxt   = 1'b1;
        w_data_nxt  = w_pay_rdata;
        w_pay_pop   = 1'b1;
        w_left_nxt  = r_left - 8'd1;
      end
      ST_DATA: begin
        if (r_left == {LEN_W{1'b0}}) begin
          w_state_nxt = ST_EOP;
          w_eop_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_DATA;
          w_vld_nxt   = 1'b1;
          w_data_nxt  = w_pay_rdata;
          w_pay_pop   = 1'b1;
          w_left_nxt  = r_left - 8'd1;
        end
      end
      ST_EOP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output FSM state, remaining-word counter and registered hydra outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_left    <= {LEN_W{1'b0}};
      r_wr_sop  <= 1'b0;
      r_wr_vld  <= 1'b0;
      r_wr_data <= 16'h0000;
      r_wr_eop  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_left    <= w_left_nxt;
      r_wr_sop  <= w_sop_nxt;
      r_wr_vld  <= w_vld_nxt;
      r_wr_data <= w_data_nxt;
      r_wr_eop  <= w_eop_nxt;
    end
  end

  assign wr_sop  = r_wr_sop;
  assign wr_vld  = r_wr_vld;
  assign wr_data = r_wr_data;
  assign wr_eop  = r_wr_eop;

`ifdef HYDRA_FRAMER_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_trunc_cnt;

  // Statistics: packets emitted (counted with wr_eop) and truncated packets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_cnt   <= 16'h0000;
      r_trunc_cnt <= 16'h0000;
    end else begin
      if (w_eop_nxt) begin
        r_pkt_cnt <= r_pkt_cnt + 16'h0001;
      end
      if (w_desc_push && w_trunc) begin
        r_trunc_cnt <= r_trunc_cnt + 16'h0001;
      end
    end
  end

  assign pkt_cnt   = r_pkt_cnt;
  assign trunc_cnt = r_trunc_cnt;
`else
  assign pkt_cnt   = 16'h0000;
  assign trunc_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hydra_ingress_framer.sv
// -----------------------------------------------------------------------------
// tb_hydra_ingress_framer
// Directed and randomized stimulus for hydra_ingress_framer. A packet-level
// reference (expected header, truncated payload, latency) is built from each
// packet sent; a monitor rebuilds emitted packets from the write framing.
// -----------------------------------------------------------------------------
module tb_hydra_ingress_framer;

  localparam int MAX_LEN = 255;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic [1:0]  s_dest;
  logic [1:0]  s_prio;
  logic        pause;
  logic        wr_sop;
  logic        wr_vld;
  logic [15:0] wr_data;
  logic        wr_eop;
  logic [15:0] pkt_cnt;
  logic [15:0] trunc_cnt;

  hydra_ingress_framer #(
    .DEPTH      (256),
    .DESC_DEPTH (4),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_dest    (s_dest),
    .s_prio    (s_prio),
    .pause     (pause),
    .wr_sop    (wr_sop),
    .wr_vld    (wr_vld),
    .wr_data   (wr_data),
    .wr_eop    (wr_eop),
    .pkt_cnt   (pkt_cnt),
    .trunc_cnt (trunc_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_pkts  = 0;
  int exp_trunc = 0;

  // Reference model: one entry per packet sent.
  logic [15:0] e_hdr[$];
  logic [15:0] e_pay[$];
  int          e_len[$];
  int          e_last[$];

  // Observed packets, completed at wr_eop.
  logic [15:0] q_hdr[$];
  logic [15:0] q_pay[$];
  int          q_n[$];
  int          q_sop[$];
  int          q_eop[$];
  int          q_gap[$];
  bit          q_bad[$];

  logic [15:0] m_words[$];
  bit m_in_pkt   = 1'b0;
  bit m_bad      = 1'b0;
  int m_sop      = 0;
  int m_vld_n    = 0;
  int m_last_vld = 0;
  int m_last_eop = -100;
  int m_gap      = 0;
  int m_sop_n    = 0;
  int m_eop_n    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int v);
`ifdef HYDRA_FRAMER_STATS_EN
    return 32'(v % 65536);
`else
    return 32'(v - v);
`endif
  endfunction

  // Monitor: rebuild packets from the write framing, flag protocol breaks.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_in_pkt = 1'b0;
        m_words.delete();
      end else begin
        if (wr_sop) begin
          m_bad    = wr_vld || wr_eop || m_in_pkt;
          m_in_pkt = 1'b1;
          m_sop    = cyc;
          m_gap    = cyc - m_last_eop;
          m_vld_n  = 0;
          m_words.delete();
          m_sop_n++;
        end
        if (wr_vld) begin
          if (!m_in_pkt) m_bad = 1'b1;
          if (m_vld_n == 0 && cyc != m_sop + 1) m_bad = 1'b1;
          if (m_vld_n > 0 && cyc != m_last_vld + 1) m_bad = 1'b1;
          m_words.push_back(wr_data);
          m_vld_n++;
          m_last_vld = cyc;
        end
        if (wr_eop) begin
          if (!m_in_pkt || wr_vld || cyc != m_last_vld + 1 || m_vld_n < 2) m_bad = 1'b1;
          q_hdr.push_back((m_words.size() > 0) ? m_words[0] : 16'hxxxx);
          for (int i = 1; i < m_words.size(); i++) q_pay.push_back(m_words[i]);
          q_n.push_back(m_vld_n - 1);
          q_sop.push_back(m_sop);
          q_eop.push_back(cyc);
          q_gap.push_back(m_gap);
          q_bad.push_back(m_bad);
          m_last_eop = cyc;
          m_in_pkt   = 1'b0;
          m_eop_n++;
        end
      end
    end
  end

  // gap: 0 contiguous, 1 idle cycle between beats, 2 random idle cycles.
  task automatic send_pkt(input int n, input int dest, input int prio, input int gap);
    logic [15:0] w;
    int len;
    int budget;
    len = (n > MAX_LEN) ? MAX_LEN : n;
    e_hdr.push_back(16'(len * 16 + prio * 4 + dest));
    e_len.push_back(len);
    if (n > MAX_LEN) exp_trunc++;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && gap == 1) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      if (i > 0 && gap == 2) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      w       = 16'($urandom);
      s_valid = 1'b1;
      s_data  = w;
      s_last  = (i == n - 1);
      // Non-first beats carry junk dest/prio: only the first beat may count.
      s_dest  = (i == 0) ? 2'(dest) : 2'($urandom);
      s_prio  = (i == 0) ? 2'(prio) : 2'($urandom);
      budget  = 0;
      while (!s_ready && budget < 1000) begin
        @(negedge clk);
        budget++;
      end
      if (!s_ready) begin
        chk("send_ready_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
      if (i < len) e_pay.push_back(w);
      if (i == n - 1) e_last.push_back(cyc);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_vld(input int k);
    int budget;
    budget = 0;
    while (!(m_in_pkt && m_vld_n >= k) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (!(m_in_pkt && m_vld_n >= k)) chk("wait_vld_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_next_pkt(input string tag, input bit lat, output int sop_c, output int gap_c);
    int budget;
    int len;
    int nw;
    int lc;
    int eop_c;
    bit bad;
    logic [15:0] eh;
    logic [15:0] oh;
    logic [15:0] ew;
    logic [15:0] ow;
    budget = 0;
    sop_c  = 0;
    gap_c  = 0;
    while (q_hdr.size() == 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (q_hdr.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    eh    = e_hdr.pop_front();
    len   = e_len.pop_front();
    lc    = e_last.pop_front();
    oh    = q_hdr.pop_front();
    nw    = q_n.pop_front();
    sop_c = q_sop.pop_front();
    eop_c = q_eop.pop_front();
    gap_c = q_gap.pop_front();
    bad   = q_bad.pop_front();
    chk({tag, "_hdr"}, 32'(oh), 32'(eh));
    chk({tag, "_len"}, 32'(nw), 32'(len));
    for (int i = 0; i < len; i++) begin
      ew = e_pay.pop_front();
      ow = (q_pay.size() > 0) ? q_pay.pop_front() : 16'hxxxx;
      chk($sformatf("%s_w%0d", tag, i), 32'(ow), 32'(ew));
    end
    for (int i = len; i < nw; i++) begin
      if (q_pay.size() > 0) void'(q_pay.pop_front());
    end
    chk({tag, "_framing"}, 32'(bad), 32'd0);
    chk({tag, "_eop_lat"}, 32'(eop_c - sop_c), 32'(len + 2));
    if (lat) chk({tag, "_sop_lat"}, 32'(sop_c - lc), 32'd2);
    exp_pkts++;
  endtask

  initial begin
    int sc;
    int gc;
    int c0;
    int n0;
    int nr;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 16'h0000;
    s_last  = 1'b0;
    s_dest  = 2'd0;
    s_prio  = 2'd0;
    pause   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wr_sop", 32'(wr_sop), 32'd0);
    chk("rst_wr_vld", 32'(wr_vld), 32'd0);
    chk("rst_wr_eop", 32'(wr_eop), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_trunc_cnt", 32'(trunc_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single 31-word packet, dest=3 prio=1 -> header 16'h01F7
    send_pkt(31, 3, 1, 0);
    check_next_pkt("single", 1'b1, sc, gc);

    // Pause holds a buffered packet; release starts it the next cycle
    pause = 1'b1;
    send_pkt(4, 2, 0, 0);
    n0 = m_sop_n;
    repeat (10) @(negedge clk);
    chk("pause_hold_sop", 32'(m_sop_n), 32'(n0));
    c0    = cyc;
    pause = 1'b0;
    check_next_pkt("pause_rel", 1'b0, sc, gc);
    chk("pause_rel_sop_cycle", 32'(sc), 32'(c0 + 1));

    // Pause raised mid-DATA does not stop the packet
    send_pkt(20, 1, 2, 0);
    wait_vld(5);
    pause = 1'b1;
    check_next_pkt("pause_mid", 1'b1, sc, gc);
    pause = 1'b0;

    // Back-to-back 1-word packets: exactly one idle cycle after each eop
    for (int k = 0; k < 3; k++) send_pkt(1, k, 3 - k, 0);
    for (int k = 0; k < 3; k++) begin
      check_next_pkt("b2b", (k == 0), sc, gc);
      if (k > 0) chk("b2b_gap", 32'(gc), 32'd2);
    end

    // Descriptor FIFO full: four queued packets drop s_ready
    pause = 1'b1;
    for (int k = 0; k < 4; k++) send_pkt(1, k, k, 0);
    chk("desc_full_ready", 32'(s_ready), 32'd0);
    pause = 1'b0;
    for (int k = 0; k < 4; k++) check_next_pkt("desc_full", 1'b0, sc, gc);
    chk("desc_drained_ready", 32'(s_ready), 32'd1);

    // Truncation: 300 words in, 255 out
    send_pkt(300, 2, 2, 0);
    check_next_pkt("trunc", 1'b1, sc, gc);
    repeat (2) @(negedge clk);
    chk("trunc_cnt", 32'(trunc_cnt), stat_exp(exp_trunc));

    // Sparse input still gives a contiguous burst
    send_pkt(8, 1, 0, 1);
    check_next_pkt("gaps", 1'b1, sc, gc);

    // Random packets, input overlapping output
    nr = 10;
    for (int k = 0; k < nr; k++)
      send_pkt($urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(0, 3), 2);
    for (int k = 0; k < nr; k++) check_next_pkt("rand", 1'b0, sc, gc);
    repeat (2) @(negedge clk);
    chk("pkt_cnt", 32'(pkt_cnt), stat_exp(exp_pkts));
    chk("trunc_cnt_all", 32'(trunc_cnt), stat_exp(exp_trunc));

    // Reset during DATA: outputs drop at once, no eop for the lost packet
    send_pkt(20, 0, 1, 0);
    wait_vld(4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wr_sop", 32'(wr_sop), 32'd0);
    chk("midrst_wr_vld", 32'(wr_vld), 32'd0);
    chk("midrst_wr_eop", 32'(wr_eop), 32'd0);
    chk("midrst_wr_data", 32'(wr_data), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    chk("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    e_hdr.delete();
    e_pay.delete();
    e_len.delete();
    e_last.delete();
    exp_pkts  = 0;
    exp_trunc = 0;
    @(negedge clk);
    n0 = m_eop_n;
    repeat (30) @(negedge clk);
    chk("midrst_no_eop", 32'(m_eop_n), 32'(n0));
    chk("midrst_no_pkt", 32'(q_hdr.size()), 32'd0);
    send_pkt(12, 2, 3, 0);
    check_next_pkt("post_rst", 1'b1, sc, gc);
    repeat (2) @(negedge clk);
    chk("post_rst_pkt_cnt", 32'(pkt_cnt), stat_exp(exp_pkts));
    chk("post_rst_trunc_cnt", 32'(trunc_cnt), stat_exp(exp_trunc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
